// File: rtl/oam_dma_bus_ctrl.sv
// rtl/oam_dma_bus_ctrl.sv - OAM DMA engine and CPU/DMA system-bus arbiter.
// Define DMA_READBACK_EN to make reads of the DMA register return the last raw value written.
module oam_dma_bus_ctrl #(
  parameter int unsigned XFER_LEN     = 160,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_blocked,
  output logic [15:0] bus_addr,
  output logic        bus_rd_en,
  output logic        bus_wr_en,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        hram_en,
  output logic        hram_we,
  input  logic [7:0]  hram_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_wr_en,
  output logic        dma_active
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_XFER  = 2'd2;

  localparam logic [1:0] SRC_BUS  = 2'd0;
  localparam logic [1:0] SRC_HRAM = 2'd1;
  localparam logic [1:0] SRC_REG  = 2'd2;
  localparam logic [1:0] SRC_BLK  = 2'd3;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  logic [1:0] state_q, state_d;
  logic [7:0] src_hi_q, src_hi_d;
  logic [7:0] idx_q, idx_d;
  logic [1:0] t_cnt_q, t_cnt_d;
  logic [7:0] byte_q, byte_d;
  logic [1:0] rsel_q, rsel_d;

  logic is_reg, is_hram, reg_wr, in_xfer, cpu_to_bus, dma_rd;

  assign is_reg     = (cpu_addr == DMA_REG_ADDR);
  assign is_hram    = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);
  assign reg_wr     = cpu_req & cpu_we & is_reg;
  assign in_xfer    = (state_q == ST_XFER);
  // Register accesses are handled locally and never reach the external bus.
  assign cpu_to_bus = cpu_req & ~is_hram & ~is_reg & ~in_xfer;
  assign dma_rd     = in_xfer & (t_cnt_q == 2'd0);

  always_comb begin
    state_d  = state_q;
    src_hi_d = src_hi_q;
    idx_d    = idx_q;
    t_cnt_d  = t_cnt_q;
    byte_d   = byte_q;
    case (state_q)
      ST_START: begin
        t_cnt_d = t_cnt_q + 2'd1;
        if (t_cnt_q == 2'd3) state_d = ST_XFER;
      end
      ST_XFER: begin
        t_cnt_d = t_cnt_q + 2'd1;
        if (t_cnt_q == 2'd1) byte_d = bus_rdata;
        if (t_cnt_q == 2'd3) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            idx_d   = 8'd0;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
    // A register write restarts from any state; E0-FF sources alias down to C0-DF.
    if (reg_wr) begin
      src_hi_d = (cpu_wdata >= 8'hE0) ? (cpu_wdata - 8'h20) : cpu_wdata;
      idx_d    = 8'd0;
      t_cnt_d  = 2'd0;
      state_d  = ST_START;
    end
  end

  always_comb begin
    rsel_d = SRC_BLK;
    if (cpu_req && !cpu_we) begin
      if (is_hram)      rsel_d = SRC_HRAM;
      else if (is_reg)  rsel_d = SRC_REG;
      else if (in_xfer) rsel_d = SRC_BLK;
      else              rsel_d = SRC_BUS;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      src_hi_q <= 8'd0;
      idx_q    <= 8'd0;
      t_cnt_q  <= 2'd0;
      byte_q   <= 8'd0;
      rsel_q   <= SRC_BLK;
    end else begin
      state_q  <= state_d;
      src_hi_q <= src_hi_d;
      idx_q    <= idx_d;
      t_cnt_q  <= t_cnt_d;
      byte_q   <= byte_d;
      rsel_q   <= rsel_d;
    end
  end

  logic [7:0] reg_rdata;
`ifdef DMA_READBACK_EN
  logic [7:0] raw_q;
  always_ff @(posedge clk) begin
    if (rst)         raw_q <= 8'd0;
    else if (reg_wr) raw_q <= cpu_wdata;
  end
  assign reg_rdata = raw_q;
`else
  assign reg_rdata = 8'hFF;
`endif

  always_comb begin
    case (rsel_q)
      SRC_BUS:  cpu_rdata = bus_rdata;
      SRC_HRAM: cpu_rdata = hram_rdata;
      SRC_REG:  cpu_rdata = reg_rdata;
      default:  cpu_rdata = 8'hFF;
    endcase
  end

  assign bus_addr    = dma_rd ? {src_hi_q, idx_q} : (cpu_to_bus ? cpu_addr : 16'h0000);
  assign bus_rd_en   = dma_rd | (cpu_to_bus & ~cpu_we);
  assign bus_wr_en   = cpu_to_bus & cpu_we;
  assign bus_wdata   = bus_wr_en ? cpu_wdata : 8'h00;
  assign cpu_blocked = cpu_req & in_xfer & ~is_hram & ~is_reg;
  assign hram_en     = cpu_req & is_hram;
  assign hram_we     = cpu_req & cpu_we & is_hram;
  assign oam_wr_en   = in_xfer & (t_cnt_q == 2'd3);
  assign oam_addr    = idx_q;
  assign oam_wdata   = byte_q;
  assign dma_active  = in_xfer;

endmodule

// File: tb/tb_oam_dma_bus_ctrl.sv
// tb/tb_oam_dma_bus_ctrl.sv - Directed table-driven bench for oam_dma_bus_ctrl.
// The external bus returns the low address byte; HRAM is a 128-byte model.
module tb_oam_dma_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cpu_blocked;
  logic [15:0] bus_addr;
  logic        bus_rd_en, bus_wr_en;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata = 8'h00;
  logic        hram_en, hram_we;
  logic [7:0]  hram_rdata = 8'h00;
  logic [7:0]  oam_addr, oam_wdata;
  logic        oam_wr_en, dma_active;

  always #5 clk = ~clk;

  oam_dma_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_blocked(cpu_blocked),
    .bus_addr(bus_addr), .bus_rd_en(bus_rd_en), .bus_wr_en(bus_wr_en),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .hram_en(hram_en), .hram_we(hram_we), .hram_rdata(hram_rdata),
    .oam_addr(oam_addr), .oam_wdata(oam_wdata), .oam_wr_en(oam_wr_en),
    .dma_active(dma_active)
  );

  bit [7:0] hram_mem [128];

  always @(posedge clk) begin
    if (bus_rd_en) bus_rdata <= bus_addr[7:0];
    if (hram_en) begin
      if (hram_we) hram_mem[cpu_addr[6:0]] <= cpu_wdata;
      hram_rdata <= hram_mem[cpu_addr[6:0]];
    end
  end

  logic [7:0]  oam_a_log [$];
  logic [7:0]  oam_d_log [$];
  logic [15:0] rd_log [$];

  always @(negedge clk) begin
    if (oam_wr_en) begin
      oam_a_log.push_back(oam_addr);
      oam_d_log.push_back(oam_wdata);
    end
    if (bus_rd_en && dma_active) rd_log.push_back(bus_addr);
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_idle();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
  endtask

  task automatic reg_write(input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF46; cpu_wdata = d;
    step();
    cpu_idle();
  endtask

  task automatic wait_active(output int n);
    n = 0;
    while (!dma_active && n < 20) begin step(); n++; end
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (dma_active && n < 1000) begin step(); n++; end
  endtask

  task automatic poll_oam(input logic [7:0] a, output bit found);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (oam_wr_en && oam_addr == a) found = 1'b1;
      else step();
    end
  endtask

  task automatic check_xfer(input string name, input logic [15:0] base);
    int bad;
    bad = 0;
    chk({name, "_oam_cnt"}, oam_a_log.size(), 160);
    chk({name, "_rd_cnt"}, rd_log.size(), 160);
    if (oam_a_log.size() == 160 && rd_log.size() == 160) begin
      for (int k = 0; k < 160; k++) begin
        if (oam_a_log[k] != 8'(k) || oam_d_log[k] != 8'(k) || rd_log[k] != base + 16'(k)) bad++;
      end
    end
    chk({name, "_seq_bad"}, bad, 0);
  endtask

  task automatic clear_logs();
    oam_a_log.delete(); oam_d_log.delete(); rd_log.delete();
  endtask

  // strb = {cpu_blocked, bus_rd_en, bus_wr_en, hram_en, hram_we}
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [4:0]  strb;
    logic [7:0]  rd;
  } vec_t;

  vec_t vecs [9];
  int   n;
  bit   found;
  logic [7:0] exp_rb;

  initial begin
    vecs[0] = '{1'b0, 16'h8000, 8'h00, 5'b01000, 8'h00};
    vecs[1] = '{1'b0, 16'hC123, 8'h00, 5'b01000, 8'h23};
    vecs[2] = '{1'b1, 16'hC000, 8'hAB, 5'b00100, 8'h00};
    vecs[3] = '{1'b1, 16'hFFA0, 8'h5A, 5'b00011, 8'h00};
    vecs[4] = '{1'b0, 16'hFFA0, 8'h00, 5'b00010, 8'h5A};
    vecs[5] = '{1'b0, 16'hFFFF, 8'h00, 5'b01000, 8'hFF};
    vecs[6] = '{1'b0, 16'hFF7F, 8'h00, 5'b01000, 8'h7F};
    vecs[7] = '{1'b1, 16'hFFFE, 8'h33, 5'b00011, 8'h00};
    vecs[8] = '{1'b0, 16'hFFFE, 8'h00, 5'b00010, 8'h33};

    rst = 1'b1;
    cpu_idle();
    repeat (3) step();
    chk("rst_strobes", {bus_rd_en, bus_wr_en, oam_wr_en, hram_en, hram_we}, 0);
    chk("rst_bus_addr", bus_addr, 16'h0000);
    chk("rst_dma_active", dma_active, 0);
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    rst = 1'b0;
    step();

    for (int i = 0; i < 9; i++) begin
      cpu_req = 1'b1; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wd;
      #1;
      chk($sformatf("vec%0d_strb", i), {cpu_blocked, bus_rd_en, bus_wr_en, hram_en, hram_we}, vecs[i].strb);
      if (vecs[i].strb[3] || vecs[i].strb[2]) chk($sformatf("vec%0d_bus_addr", i), bus_addr, vecs[i].addr);
      if (vecs[i].strb[2]) chk($sformatf("vec%0d_bus_wdata", i), bus_wdata, vecs[i].wd);
      step();
      cpu_idle();
      #1;
      if (!vecs[i].we) chk($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].rd);
    end

    clear_logs();
    reg_write(8'hC1);
    chk("c1_strobe_after_write", {bus_rd_en, bus_wr_en}, 0);
    wait_active(n);
    chk("c1_start_len", n, 4);
    wait_idle(n);
    chk("c1_total_latency", 4 + n, 644);
    check_xfer("c1", 16'hC100);

    clear_logs();
    reg_write(8'hE3);
    wait_active(n);
    chk("e3_start_len", n, 4);
    repeat (10) step();
    chk("e3_first_rd", rd_log.size() > 0 ? rd_log[0] : 16'hDEAD, 16'hC300);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
    #1;
    chk("xfer_blocked", cpu_blocked, 1);
    chk("xfer_no_cpu_strobe", {bus_wr_en, (bus_rd_en && bus_addr == 16'h8000)}, 0);
    step();
    cpu_idle();
    #1;
    chk("xfer_blocked_rdata", cpu_rdata, 8'hFF);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'hFF90; cpu_wdata = 8'h5A;
    #1;
    chk("xfer_hram_we", {hram_en, hram_we, cpu_blocked}, 3'b110);
    step();
    cpu_we = 1'b0;
    step();
    cpu_idle();
    #1;
    chk("xfer_hram_rdata", cpu_rdata, 8'h5A);
    wait_idle(n);
    check_xfer("e3", 16'hC300);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'hFF46;
    #1;
    chk("reg_read_no_bus", {bus_rd_en, bus_wr_en, cpu_blocked}, 0);
    step();
    cpu_idle();
    #1;
`ifdef DMA_READBACK_EN
    exp_rb = 8'hE3;
`else
    exp_rb = 8'hFF;
`endif
    chk("reg_readback", cpu_rdata, exp_rb);

    clear_logs();
    reg_write(8'hC1);
    poll_oam(8'd49, found);
    chk("rs_found49", found, 1);
    step();
    chk("rs_idx50_rd", {bus_rd_en, bus_addr}, {1'b1, 16'hC132});
    step();
    reg_write(8'hC0);
    chk("rs_last_before", oam_a_log.size() > 0 ? oam_a_log[$] : 8'hEE, 8'd49);
    chk("rs_start_inactive", dma_active, 0);
    clear_logs();
    wait_active(n);
    chk("rs_start_len", n, 4);
    wait_idle(n);
    check_xfer("rs", 16'hC000);

    clear_logs();
    reg_write(8'hC1);
    poll_oam(8'd79, found);
    chk("rst_found79", found, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_strobes", {bus_rd_en, bus_wr_en, oam_wr_en, hram_en, hram_we}, 0);
    chk("mid_rst_dma_active", dma_active, 0);
    chk("mid_rst_rdata", cpu_rdata, 8'hFF);
    clear_logs();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h8000;
    #1;
    chk("mid_rst_pass", {bus_rd_en, cpu_blocked, bus_addr}, {1'b1, 1'b0, 16'h8000});
    step();
    cpu_idle();
    #1;
    chk("mid_rst_pass_rdata", cpu_rdata, 8'h00);
    repeat (400) step();
    chk("mid_rst_no_oam", oam_a_log.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
